pid_ctrl: RTL and testbench
===========================

# pid_ctrl

Parametrised PID angle controller for the swerve rotation motors, sitting between the I2C encoder-read path and the PWM generator. Each encoder sample is turned into a wrap-aware signed error, a P/I/D term set with saturation and anti-windup, and a slew-limited PWM ratio plus direction. Adds what the fixed 12-bit controller lacks: configurable widths, bounded integrator, settle-time completion, stall detection and a pipelined update with a defined latency.

## Interface
- ANGLE_W, 12, encoder/target angle width; one rotation = 2^ANGLE_W counts
- PWM_W, 8, pwm_ratio width
- I_MAX, 4095, integrator clamp (unsigned, counts·samples)
- RAMP_STEP, 8, max pwm_ratio increase per sample in ACCEL
- DECEL_TOL, 50, |error| below which DECEL is entered
- DONE_TOL, 4, |error| at or below which a sample counts as settled
- SETTLE_N, 4, consecutive settled samples required for done
- STALL_N, 16, consecutive non-moving samples that declare a stall
- clock  in  1  main clock
- reset_n  in  1  asynchronous, active-low reset
- target_angle  in  ANGLE_W  commanded angle, captured on angle_update
- current_angle  in  ANGLE_W  encoder angle, valid with sample_valid
- sample_valid  in  1  one-cycle pulse per completed encoder read
- angle_update  in  1  start a move to target_angle
- abort_angle  in  1  stop immediately
- pwm_enable  in  1  PWM stage enabled; low forces IDLE
- enable_stall_chk  in  1  enable stall detection
- kp  in  8  proportional gain, unsigned 4.4
- ki  in  8  integral gain, unsigned 0.8
- kd  in  8  derivative gain, unsigned 4.4
- pwm_ratio  out  PWM_W  duty high-time
- pwm_direction  out  1  1 = positive error (increasing angle)
- pwm_update  out  1  one-cycle pulse, new pwm_ratio valid
- angle_done  out  1  sticky; set on settle, cleared by angle_update
- stalled  out  1  sticky; cleared by angle_update or reset
- debug_signals  out  16  {8'b0, settle_cnt[2:0], stall_flag, pwm_direction, state[2:0]}

## Operation
- States: IDLE, ACCEL, CRUISE, DECEL, SETTLE. angle_update in any state: capture target, clear integrator/angle_done/stalled/counters, go ACCEL.
- Error: err = signed wrap of (target − current) in ANGLE_W bits, range [−2^(ANGLE_W−1), 2^(ANGLE_W−1)−1]; mag = |err| (most-negative maps to 2^(ANGLE_W−1)); direction = err > 0.
- P = (kp·mag)>>4. I: acc += mag per sample, clamped to I_MAX; acc cleared when err sign flips (anti-windup); I = (ki·acc)>>8. D = (kd·(mag − last_mag))>>4, signed. raw = P+I+D, clamped to [0, 2^PWM_W−1].
- ACCEL: pwm_ratio = min(raw, prev+RAMP_STEP); → CRUISE when raw ≤ prev+RAMP_STEP.
- CRUISE: pwm_ratio = raw; mag < DECEL_TOL → DECEL.
- DECEL: pwm_ratio = raw; mag ≤ DONE_TOL → SETTLE; mag ≥ DECEL_TOL → CRUISE.
- SETTLE: pwm_ratio = 0; settle_cnt++ per settled sample, reset on unsettled sample (→ DECEL); settle_cnt = SETTLE_N → angle_done=1, IDLE.
- Stall (ACCEL/CRUISE/DECEL, enable_stall_chk=1, pwm_ratio ≠ 0): stall_cnt++ when mag == last_mag, else cleared; reaching STALL_N → stalled=1, IDLE.
- abort_angle or pwm_enable=0: IDLE, pwm_ratio=0 next cycle, one pwm_update pulse; angle_done unchanged. abort wins over simultaneous angle_update.
- IDLE: pwm_ratio held 0; samples update only last_mag.

## Timing
- Reset: pwm_ratio=0, pwm_direction=0, pwm_update=0, angle_done=0, stalled=0, state IDLE, acc=0, all counters 0.
- Two-stage pipeline: sample at cycle N → error/terms registered N+1 → pwm_ratio, direction, pwm_update pulse, state change at N+2.
- sample_valid during busy pipeline is accepted (fully pipelined, one sample per cycle).
- angle_update coincident with sample_valid: that sample uses the new target.
- Reset asserted mid-move: outputs go to reset values asynchronously.

## Structure
- Shared pid_pkg: state enum (3-bit), debug field offsets, saturate/abs helper functions.
- Sub-module pid_error_stage: wrap-aware error, mag, direction, registered stage 1. Top holds integrator, FSM, slew, counters.

## Test plan
- target 100, current 4000 (wrap): direction=1, mag=196, pwm_ratio at N+2 ≤ RAMP_STEP=8.
- kp=0x10, ki=kd=0, steady mag 20 for SETTLE_N samples then 2: reaches SETTLE, angle_done=1 after 4 samples ≤ 4.
- Constant current_angle with pwm_ratio>0, enable_stall_chk=1: stalled=1 after 16 samples, pwm_ratio=0.
- ki=0xFF, mag 2000 for 10 samples: acc clamps at 4095; error sign flip → acc=0.
- abort_angle during CRUISE together with angle_update: IDLE, pwm_ratio=0, single pwm_update.
- kp=0xFF, mag 2048: raw saturates, pwm_ratio=255 in CRUISE, no wrap.

Source files
------------

// File: rtl/pid_pkg.sv
// Shared types and helpers for the swerve rotation PID controller.
package pid_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEL  = 3'd1,
    CRUISE = 3'd2,
    DECEL  = 3'd3,
    SETTLE = 3'd4
  } pid_state_t;

  // debug_signals field positions
  localparam int DBG_STATE_LSB  = 0;
  localparam int DBG_DIR_BIT    = 3;
  localparam int DBG_STALL_BIT  = 4;
  localparam int DBG_SETTLE_LSB = 5;

  function automatic int sat_int(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int abs_int(input int v);
    return (v < 0) ? -v : v;
  endfunction

endpackage

// File: rtl/pid_error_stage.sv
// Stage 1: wrap-aware angle error, magnitude and direction, registered.
module pid_error_stage
  import pid_pkg::*;
#(
  parameter int ANGLE_W = 12
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               sample_valid,
  input  logic [ANGLE_W-1:0] target_angle,
  input  logic [ANGLE_W-1:0] current_angle,
  output logic               err_valid,
  output logic [ANGLE_W:0]   err_mag,
  output logic               err_neg,
  output logic               err_dir
);

  logic [ANGLE_W-1:0] diff;
  int                 err_s;

  // Modular difference reinterpreted as signed gives the shortest-path error
  always_comb begin
    diff  = target_angle - current_angle;
    err_s = int'($signed(diff));
  end

  // Register error terms for the sample
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_valid <= 1'b0;
      err_mag   <= '0;
      err_neg   <= 1'b0;
      err_dir   <= 1'b0;
    end else begin
      err_valid <= sample_valid;
      if (sample_valid) begin
        err_mag <= (ANGLE_W+1)'(abs_int(err_s));
        err_neg <= diff[ANGLE_W-1];
        err_dir <= (err_s > 0);
      end
    end
  end

endmodule

// File: rtl/pid_ctrl.sv
// PID angle controller: integrator, motion FSM, slew limit, settle and stall tracking.
module pid_ctrl
  import pid_pkg::*;
#(
  parameter int ANGLE_W   = 12,
  parameter int PWM_W     = 8,
  parameter int I_MAX     = 4095,
  parameter int RAMP_STEP = 8,
  parameter int DECEL_TOL = 50,
  parameter int DONE_TOL  = 4,
  parameter int SETTLE_N  = 4,
  parameter int STALL_N   = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [ANGLE_W-1:0] target_angle,
  input  logic [ANGLE_W-1:0] current_angle,
  input  logic               sample_valid,
  input  logic               angle_update,
  input  logic               abort_angle,
  input  logic               pwm_enable,
  input  logic               enable_stall_chk,
  input  logic [7:0]         kp,
  input  logic [7:0]         ki,
  input  logic [7:0]         kd,
  output logic [PWM_W-1:0]   pwm_ratio,
  output logic               pwm_direction,
  output logic               pwm_update,
  output logic               angle_done,
  output logic               stalled,
  output logic [15:0]        debug_signals
);

  localparam int PWM_MAX = (1 << PWM_W) - 1;
  localparam int ACC_W   = $clog2(I_MAX + 1);

  pid_state_t         state_q, state_d;
  logic [ANGLE_W-1:0] target_q, target_d, eff_target;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ANGLE_W:0]   last_mag_q, last_mag_d;
  logic               last_neg_q, last_neg_d, have_sign_q, have_sign_d;
  logic [15:0]        settle_q, settle_d, stall_q, stall_d;
  logic [PWM_W-1:0]   ratio_q, ratio_d;
  logic               dir_q, dir_d, upd_d, done_q, done_d, stalled_q, stalled_d;
  logic               kill, kill_q, flip, stall_arm;

  logic               err_valid, err_neg, err_dir;
  logic [ANGLE_W:0]   err_mag;

  int mag_i, acc_sum, acc_next, p_term, i_term, d_term, raw, lim, stall_next, settle_next;

  assign kill = abort_angle || !pwm_enable;
  // A sample arriving with angle_update is measured against the new target
  assign eff_target = (angle_update && !kill) ? target_angle : target_q;

  pid_error_stage #(.ANGLE_W(ANGLE_W)) u_err (
    .clock         (clock),
    .reset_n       (reset_n),
    .sample_valid  (sample_valid),
    .target_angle  (eff_target),
    .current_angle (current_angle),
    .err_valid     (err_valid),
    .err_mag       (err_mag),
    .err_neg       (err_neg),
    .err_dir       (err_dir)
  );

  // Stage 2: PID terms, next state and next outputs
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    acc_d       = acc_q;
    last_mag_d  = last_mag_q;
    last_neg_d  = last_neg_q;
    have_sign_d = have_sign_q;
    settle_d    = settle_q;
    stall_d     = stall_q;
    ratio_d     = ratio_q;
    dir_d       = dir_q;
    done_d      = done_q;
    stalled_d   = stalled_q;
    upd_d       = 1'b0;

    mag_i       = int'(err_mag);
    acc_sum     = int'(acc_q) + mag_i;
    flip        = have_sign_q && (err_mag != '0) && (err_neg != last_neg_q);
    acc_next    = flip ? 0 : ((acc_sum > I_MAX) ? I_MAX : acc_sum);
    p_term      = (int'(kp) * mag_i) >>> 4;
    i_term      = (int'(ki) * acc_next) >>> 8;
    d_term      = (int'(kd) * (mag_i - int'(last_mag_q))) >>> 4;
    raw         = sat_int(p_term + i_term + d_term, 0, PWM_MAX);
    lim         = sat_int(int'(ratio_q) + RAMP_STEP, 0, PWM_MAX);
    stall_next  = (err_mag == last_mag_q) ? int'(stall_q) + 1 : 0;
    settle_next = int'(settle_q) + 1;
    stall_arm   = enable_stall_chk && (ratio_q != '0) &&
                  (state_q inside {ACCEL, CRUISE, DECEL});

    if (kill) begin
      state_d = IDLE;
      ratio_d = '0;
      upd_d   = !kill_q;
      if (err_valid) last_mag_d = err_mag;
    end else if (angle_update) begin
      // The in-flight stage-1 sample belongs to the old target and is dropped
      target_d    = target_angle;
      acc_d       = '0;
      done_d      = 1'b0;
      stalled_d   = 1'b0;
      settle_d    = '0;
      stall_d     = '0;
      have_sign_d = 1'b0;
      state_d     = ACCEL;
      if (err_valid) last_mag_d = err_mag;
    end else if (err_valid) begin
      last_mag_d = err_mag;
      if (state_q != IDLE) begin
        upd_d = 1'b1;
        dir_d = err_dir;
        acc_d = ACC_W'(acc_next);
        if (err_mag != '0) begin
          have_sign_d = 1'b1;
          last_neg_d  = err_neg;
        end
        stall_d = stall_arm ? 16'(stall_next) : '0;
        case (state_q)
          ACCEL: begin
            if (raw <= lim) begin
              ratio_d = PWM_W'(raw);
              state_d = CRUISE;
            end else begin
              ratio_d = PWM_W'(lim);
            end
          end
          CRUISE: begin
            ratio_d = PWM_W'(raw);
            if (mag_i < DECEL_TOL) state_d = DECEL;
          end
          DECEL: begin
            ratio_d = PWM_W'(raw);
            if (mag_i <= DONE_TOL) begin
              state_d  = SETTLE;
              settle_d = '0;
            end else if (mag_i >= DECEL_TOL) begin
              state_d = CRUISE;
            end
          end
          SETTLE: begin
            ratio_d = '0;
            if (mag_i <= DONE_TOL) begin
              settle_d = 16'(settle_next);
              if (settle_next >= SETTLE_N) begin
                done_d  = 1'b1;
                state_d = IDLE;
              end
            end else begin
              settle_d = '0;
              state_d  = DECEL;
            end
          end
          default: ;
        endcase
        if (stall_arm && (stall_next >= STALL_N)) begin
          stalled_d = 1'b1;
          state_d   = IDLE;
          ratio_d   = '0;
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      target_q    <= '0;
      acc_q       <= '0;
      last_mag_q  <= '0;
      last_neg_q  <= 1'b0;
      have_sign_q <= 1'b0;
      settle_q    <= '0;
      stall_q     <= '0;
      ratio_q     <= '0;
      dir_q       <= 1'b0;
      done_q      <= 1'b0;
      stalled_q   <= 1'b0;
      pwm_update  <= 1'b0;
      kill_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      acc_q       <= acc_d;
      last_mag_q  <= last_mag_d;
      last_neg_q  <= last_neg_d;
      have_sign_q <= have_sign_d;
      settle_q    <= settle_d;
      stall_q     <= stall_d;
      ratio_q     <= ratio_d;
      dir_q       <= dir_d;
      done_q      <= done_d;
      stalled_q   <= stalled_d;
      pwm_update  <= upd_d;
      kill_q      <= kill;
    end
  end

  assign pwm_ratio     = ratio_q;
  assign pwm_direction = dir_q;
  assign angle_done    = done_q;
  assign stalled       = stalled_q;
  assign debug_signals = {8'b0, settle_q[2:0], stalled_q, dir_q, 3'(state_q)};

endmodule

// File: tb/tb_pid_ctrl.sv
// Scoreboard bench for pid_ctrl with directed vectors.
module tb_pid_ctrl;
  import pid_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [11:0] target_angle, current_angle;
  logic        sample_valid, angle_update, abort_angle, pwm_enable, enable_stall_chk;
  logic [7:0]  kp, ki, kd;
  logic [7:0]  pwm_ratio;
  logic        pwm_direction, pwm_update, angle_done, stalled;
  logic [15:0] debug_signals;

  pid_ctrl #(
    .ANGLE_W(12), .PWM_W(8), .I_MAX(4095), .RAMP_STEP(8),
    .DECEL_TOL(50), .DONE_TOL(4), .SETTLE_N(4), .STALL_N(16)
  ) dut (
    .clock(clock), .reset_n(reset_n), .target_angle(target_angle),
    .current_angle(current_angle), .sample_valid(sample_valid),
    .angle_update(angle_update), .abort_angle(abort_angle),
    .pwm_enable(pwm_enable), .enable_stall_chk(enable_stall_chk),
    .kp(kp), .ki(ki), .kd(kd), .pwm_ratio(pwm_ratio),
    .pwm_direction(pwm_direction), .pwm_update(pwm_update),
    .angle_done(angle_done), .stalled(stalled), .debug_signals(debug_signals)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int ratio; int dir; int st; int done; int stl; int cyc;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  task automatic push_exp(input int lat, input int r, input int d, input int st,
                          input int dn, input int sl);
    exp_t e;
    e.ratio = r; e.dir = d; e.st = st; e.done = dn; e.stl = sl; e.cyc = cyc + lat;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; one sample pulse, then two idle cycles
  task automatic drive_sample(input int cur, input bit upd, input int tgt, input bit has,
                              input int r, input int d, input int st,
                              input int dn, input int sl);
    if (has) push_exp(2, r, d, st, dn, sl);
    current_angle = 12'(cur);
    if (upd) target_angle = 12'(tgt);
    angle_update  = upd;
    sample_valid  = 1'b1;
    @(negedge clock);
    sample_valid  = 1'b0;
    angle_update  = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic do_abort(input bit with_upd, input int d, input int dn, input int sl);
    push_exp(1, 0, d, int'(IDLE), dn, sl);
    abort_angle  = 1'b1;
    angle_update = with_upd;
    target_angle = 12'd5;
    @(negedge clock);
    abort_angle  = 1'b0;
    angle_update = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  // Monitor: every pwm_update pulse must match the next expected entry
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (reset_n && pwm_update) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_update: got pwm_update=1 ratio=%0d expected no update (cycle %0d)",
                   pwm_ratio, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("latency",    cyc, e.cyc);
          chk("pwm_ratio",  int'(pwm_ratio), e.ratio);
          chk("direction",  int'(pwm_direction), e.dir);
          chk("state",      int'(debug_signals[2:0]), e.st);
          chk("angle_done", int'(angle_done), e.done);
          chk("stalled",    int'(stalled), e.stl);
        end
      end
    end
  end

  initial begin
    #200000;
    n_checks++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    reset_n = 1'b0; target_angle = '0; current_angle = '0; sample_valid = 1'b0;
    angle_update = 1'b0; abort_angle = 1'b0; pwm_enable = 1'b1; enable_stall_chk = 1'b0;
    kp = 8'h10; ki = 8'h00; kd = 8'h00;
    repeat (3) @(negedge clock);
    chk("rst_ratio",  int'(pwm_ratio), 0);
    chk("rst_dir",    int'(pwm_direction), 0);
    chk("rst_update", int'(pwm_update), 0);
    chk("rst_done",   int'(angle_done), 0);
    chk("rst_stalled", int'(stalled), 0);
    chk("rst_debug",  int'(debug_signals), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Wrap: target 100, current 4000 -> error +196, ramp-limited
    drive_sample(4000, 1, 100, 1,  8, 1, int'(ACCEL), 0, 0);
    drive_sample(4000, 0, 0,   1, 16, 1, int'(ACCEL), 0, 0);
    drive_sample(4000, 0, 0,   1, 24, 1, int'(ACCEL), 0, 0);
    do_abort(0, 1, 0, 0);
    chk("abort_state", int'(debug_signals[2:0]), int'(IDLE));

    // Saturation: kp=0xFF, mag 2048 (most-negative error), ramp to 255
    kp = 8'hFF;
    for (int k = 1; k <= 33; k++) begin
      drive_sample(0, (k == 1), 2048, 1, (8 * k > 255) ? 255 : 8 * k, 0,
                   (k >= 32) ? int'(CRUISE) : int'(ACCEL), 0, 0);
    end
    do_abort(1, 0, 0, 0);
    drive_sample(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("abort_upd_state", int'(debug_signals[2:0]), int'(IDLE));

    // Settle: mag 20 x4, then mag 2 with one unsettled interruption
    kp = 8'h10;
    drive_sample(0,  1, 20, 1,  8, 1, int'(ACCEL),  0, 0);
    drive_sample(0,  0, 0,  1, 16, 1, int'(ACCEL),  0, 0);
    drive_sample(0,  0, 0,  1, 20, 1, int'(CRUISE), 0, 0);
    drive_sample(0,  0, 0,  1, 20, 1, int'(DECEL),  0, 0);
    drive_sample(18, 0, 0,  1,  2, 1, int'(SETTLE), 0, 0);
    drive_sample(18, 0, 0,  1,  0, 1, int'(SETTLE), 0, 0);
    drive_sample(10, 0, 0,  1,  0, 1, int'(DECEL),  0, 0);
    drive_sample(18, 0, 0,  1,  2, 1, int'(SETTLE), 0, 0);
    drive_sample(18, 0, 0,  1,  0, 1, int'(SETTLE), 0, 0);
    drive_sample(18, 0, 0,  1,  0, 1, int'(SETTLE), 0, 0);
    drive_sample(18, 0, 0,  1,  0, 1, int'(SETTLE), 0, 0);
    drive_sample(18, 0, 0,  1,  0, 1, int'(IDLE),   1, 0);
    drive_sample(18, 0, 0,  0,  0, 0, 0, 0, 0);
    chk("done_sticky", int'(angle_done), 1);
    chk("dbg_settle",  int'(debug_signals[7:5]), 4);

    // Integrator: ki=1, mag 2000 -> acc 2000, 4000, clamp 4095; sign flip clears
    kp = 8'h00; ki = 8'h01;
    drive_sample(0,    1, 2000, 1,  7, 1, int'(CRUISE), 0, 0);
    drive_sample(0,    0, 0,    1, 15, 1, int'(CRUISE), 0, 0);
    drive_sample(0,    0, 0,    1, 15, 1, int'(CRUISE), 0, 0);
    drive_sample(0,    0, 0,    1, 15, 1, int'(CRUISE), 0, 0);
    drive_sample(4000, 0, 0,    1,  0, 0, int'(CRUISE), 0, 0);
    drive_sample(4000, 0, 0,    1,  7, 0, int'(CRUISE), 0, 0);
    do_abort(0, 0, 0, 0);

    // Stall: constant mag 100 with pwm_ratio > 0
    kp = 8'h10; ki = 8'h00; enable_stall_chk = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      drive_sample(0, (k == 1), 100, 1,
                   (k == 17) ? 0 : ((8 * k > 100) ? 100 : 8 * k), 1,
                   (k == 17) ? int'(IDLE) : ((k >= 13) ? int'(CRUISE) : int'(ACCEL)),
                   0, (k == 17) ? 1 : 0);
    end
    drive_sample(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("stall_sticky", int'(stalled), 1);
    chk("dbg_stall",    int'(debug_signals[DBG_STALL_BIT]), 1);
    angle_update = 1'b1; target_angle = 12'd100;
    @(negedge clock);
    angle_update = 1'b0;
    chk("stall_cleared", int'(stalled), 0);
    chk("update_state",  int'(debug_signals[2:0]), int'(ACCEL));
    @(negedge clock);
    do_abort(0, 1, 0, 0);

    // Derivative: kd=2.0, mag 100 -> 30 (clamped at 0), then 30 -> 60
    kp = 8'h00; kd = 8'h20; enable_stall_chk = 1'b0;
    drive_sample(70, 1, 100, 1,  0, 1, int'(CRUISE), 0, 0);
    drive_sample(40, 0, 0,   1, 60, 1, int'(CRUISE), 0, 0);

    // pwm_enable low: single pulse to zero, held low for several cycles
    push_exp(1, 0, 1, int'(IDLE), 0, 0);
    pwm_enable = 1'b0;
    repeat (6) @(negedge clock);
    chk("disable_ratio", int'(pwm_ratio), 0);
    pwm_enable = 1'b1;
    @(negedge clock);

    // Asynchronous reset during a move
    kp = 8'h10; kd = 8'h00;
    drive_sample(0, 1, 100, 1, 8, 1, int'(ACCEL), 0, 0);
    chk("pre_reset_ratio", int'(pwm_ratio), 8);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_ratio", int'(pwm_ratio), 0);
    chk("async_rst_dir",   int'(pwm_direction), 0);
    chk("async_rst_debug", int'(debug_signals), 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
